// File: rtl/game_phase_sequencer.sv
// ---------------------------------------------------------------------------
// game_phase_sequencer
//
// Game-flow controller for the bomb defusal game. Walks IDLE -> PHASE 1..N ->
// CLEAR or OVER, keeps the stability score, and drives the game timer control
// and status flags. Phase advances are gated by a short settle window after
// every phase entry. A debug jump can force any puzzle phase.
//
// State codes: 0 = IDLE, k = PHASE k (1..NUM_PHASES),
//              NUM_PHASES+1 = CLEAR, NUM_PHASES+2 = OVER.
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-high reset
//   start_btn      start / acknowledge pulse
//   phase_clear    current phase solved
//   time_out       game timer expired
//   puzzle_fail    wrong answer, costs FAIL_PENALTY stability
//   event_fail     failed event, costs EVENT_PENALTY stability
//   puzzle_correct recovery, gains RECOVER_STEP stability
//   debug_force    debug jump request
//   debug_state    target phase of the debug jump
//   current_state  registered state code
//   stability      registered stability score
//   game_enable    high in any PHASE state
//   timer_reset    one-cycle pulse on game start and every debug jump
//   phase_enter    one-cycle pulse on every entry into a PHASE state
//   game_clear     high in CLEAR
//   game_over      high in OVER
// ---------------------------------------------------------------------------
module game_phase_sequencer #(
  parameter int NUM_PHASES    = 4,
  parameter int STATE_W       = 4,
  parameter int STAB_W        = 4,
  parameter int STAB_MAX      = 9,
  parameter int FAIL_PENALTY  = 1,
  parameter int EVENT_PENALTY = 2,
  parameter int RECOVER_STEP  = 1,
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBUG_EN      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               phase_clear,
  input  logic               time_out,
  input  logic               puzzle_fail,
  input  logic               event_fail,
  input  logic               puzzle_correct,
  input  logic               debug_force,
  input  logic [STATE_W-1:0] debug_state,
  output logic [STATE_W-1:0] current_state,
  output logic [STAB_W-1:0]  stability,
  output logic               game_enable,
  output logic               timer_reset,
  output logic               phase_enter,
  output logic               game_clear,
  output logic               game_over
);

  // Coarse view of the numeric state code; the phase number itself stays in
  // current_state so the phase count can be a parameter.
  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_PHASE,
    MODE_CLEAR,
    MODE_OVER
  } mode_t;

  localparam logic [STATE_W-1:0] S_IDLE  = '0;
  localparam logic [STATE_W-1:0] S_FIRST = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_LAST  = STATE_W'(NUM_PHASES);
  localparam logic [STATE_W-1:0] S_CLEAR = STATE_W'(NUM_PHASES + 1);
  localparam logic [STATE_W-1:0] S_OVER  = STATE_W'(NUM_PHASES + 2);

  localparam int                  SETTLE_W    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

  // Three guard bits cover the worst-case underflow and overflow of one update.
  localparam int                       WIDE_W    = STAB_W + 3;
  localparam logic signed [WIDE_W-1:0] FAIL_W    = WIDE_W'(FAIL_PENALTY);
  localparam logic signed [WIDE_W-1:0] EVENT_W   = WIDE_W'(EVENT_PENALTY);
  localparam logic signed [WIDE_W-1:0] RECOVER_W = WIDE_W'(RECOVER_STEP);
  localparam logic signed [WIDE_W-1:0] MAX_W     = WIDE_W'(STAB_MAX);
  localparam logic [STAB_W-1:0]        STAB_TOP  = STAB_W'(STAB_MAX);

  mode_t                      mode;
  logic                       debug_hit;
  logic signed [WIDE_W-1:0]   stab_wide;
  logic [STAB_W-1:0]          stab_next;
  logic [SETTLE_W-1:0]        settle;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    mode = MODE_OVER;
    if (current_state == S_IDLE) begin
      mode = MODE_IDLE;
    end else if (current_state <= S_LAST) begin
      mode = MODE_PHASE;
    end else if (current_state == S_CLEAR) begin
      mode = MODE_CLEAR;
    end
  end

  assign debug_hit = (DEBUG_EN != 0) && debug_force &&
                     (debug_state != S_IDLE) && (debug_state <= S_LAST);

  // All score inputs of one cycle fold into a single signed update, then the
  // result is clamped to [0, STAB_MAX].
  always_comb begin
    stab_wide = $signed({3'b000, stability});
    if (puzzle_fail)    stab_wide = stab_wide - FAIL_W;
    if (event_fail)     stab_wide = stab_wide - EVENT_W;
    if (puzzle_correct) stab_wide = stab_wide + RECOVER_W;

    if (stab_wide[WIDE_W-1]) begin
      stab_next = '0;
    end else if (stab_wide > MAX_W) begin
      stab_next = STAB_TOP;
    end else begin
      stab_next = stab_wide[STAB_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; a later
  // assignment in the same branch overrides an earlier default.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      current_state <= S_IDLE;
      stability     <= STAB_TOP;
      settle        <= '0;
      game_enable   <= 1'b0;
      timer_reset   <= 1'b0;
      phase_enter   <= 1'b0;
      game_clear    <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      timer_reset <= 1'b0;
      phase_enter <= 1'b0;

      if (debug_hit) begin
        current_state <= debug_state;
        settle        <= SETTLE_LOAD;
        game_enable   <= 1'b1;
        game_clear    <= 1'b0;
        game_over     <= 1'b0;
        timer_reset   <= 1'b1;
        phase_enter   <= 1'b1;
        // A jump out of a finished game starts with a full score.
        if (mode == MODE_CLEAR || mode == MODE_OVER) begin
          stability <= STAB_TOP;
        end
      end else begin
        unique case (mode)
          MODE_IDLE: begin
            if (start_btn) begin
              current_state <= S_FIRST;
              stability     <= STAB_TOP;
              settle        <= SETTLE_LOAD;
              game_enable   <= 1'b1;
              timer_reset   <= 1'b1;
              phase_enter   <= 1'b1;
            end
          end

          MODE_PHASE: begin
            if (settle != '0) begin
              settle <= settle - SETTLE_W'(1);
            end

            if (time_out) begin
              current_state <= S_OVER;
              game_enable   <= 1'b0;
              game_over     <= 1'b1;
            end else if (stab_next == '0) begin
              stability     <= '0;
              current_state <= S_OVER;
              game_enable   <= 1'b0;
              game_over     <= 1'b1;
            end else begin
              stability <= stab_next;
              // A clear during the settle window is dropped, not remembered.
              if (phase_clear && settle == '0) begin
                if (current_state == S_LAST) begin
                  current_state <= S_CLEAR;
                  game_enable   <= 1'b0;
                  game_clear    <= 1'b1;
                end else begin
                  current_state <= current_state + S_FIRST;
                  settle        <= SETTLE_LOAD;
                  phase_enter   <= 1'b1;
                end
              end
            end
          end

          MODE_CLEAR, MODE_OVER: begin
            // Terminal: only an acknowledge returns to IDLE.
            if (start_btn) begin
              current_state <= S_IDLE;
              stability     <= STAB_TOP;
              game_clear    <= 1'b0;
              game_over     <= 1'b0;
            end
          end

          default: begin
            current_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_game_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_phase_sequencer
//
// Self-checking bench for game_phase_sequencer with default parameters:
// a directed vector table, hand-written multi-cycle sequences (full game,
// asynchronous reset), and randomized stimulus against a reference model.
// ---------------------------------------------------------------------------
module tb_game_phase_sequencer;

  localparam int NP     = 4;
  localparam int SMAX   = 9;
  localparam int FP     = 1;
  localparam int EP     = 2;
  localparam int RS     = 1;
  localparam int SETTLE = 4;
  localparam int ST_CLEAR = NP + 1;
  localparam int ST_OVER  = NP + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn, phase_clear, time_out;
  logic       puzzle_fail, event_fail, puzzle_correct, debug_force;
  logic [3:0] debug_state;
  logic [3:0] current_state;
  logic [3:0] stability;
  logic       game_enable, timer_reset, phase_enter, game_clear, game_over;

  always #10 clk = ~clk;

  game_phase_sequencer #(
    .NUM_PHASES(NP), .STATE_W(4), .STAB_W(4), .STAB_MAX(SMAX),
    .FAIL_PENALTY(FP), .EVENT_PENALTY(EP), .RECOVER_STEP(RS),
    .SETTLE_CYCLES(SETTLE), .DEBUG_EN(1)
  ) dut (
    .clk(clk), .rst(rst),
    .start_btn(start_btn), .phase_clear(phase_clear), .time_out(time_out),
    .puzzle_fail(puzzle_fail), .event_fail(event_fail),
    .puzzle_correct(puzzle_correct), .debug_force(debug_force),
    .debug_state(debug_state),
    .current_state(current_state), .stability(stability),
    .game_enable(game_enable), .timer_reset(timer_reset),
    .phase_enter(phase_enter), .game_clear(game_clear), .game_over(game_over)
  );

  // One clock of stimulus plus the outputs expected after that edge.
  typedef struct {
    int start, clr, tout, pf, ef, pc, df, ds;
    int e_state, e_stab, e_en, e_trst, e_pent, e_clear, e_over;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: game position, score, and cycles spent in current phase.
  int m_state, m_stab, m_age, m_trst, m_pent;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_stab = SMAX; m_age = 0; m_trst = 0; m_pent = 0;
  endtask

  function automatic int clamp(input int x);
    if (x < 0)    return 0;
    if (x > SMAX) return SMAX;
    return x;
  endfunction

  task automatic enter_phase(input int p);
    m_state = p; m_age = 0; m_pent = 1;
  endtask

  task automatic model_step(input vec_t v);
    int score;
    bit in_game;
    m_trst  = 0;
    m_pent  = 0;
    in_game = (m_state >= 1 && m_state <= NP);
    if (v.df != 0 && v.ds >= 1 && v.ds <= NP) begin
      if (m_state == ST_CLEAR || m_state == ST_OVER) m_stab = SMAX;
      enter_phase(v.ds);
      m_trst = 1;
    end else if (m_state == 0) begin
      if (v.start != 0) begin
        m_stab = SMAX;
        enter_phase(1);
        m_trst = 1;
      end
    end else if (in_game) begin
      score = clamp(m_stab - FP * v.pf - EP * v.ef + RS * v.pc);
      if (v.tout != 0) begin
        m_state = ST_OVER;
      end else if (score == 0) begin
        m_stab  = 0;
        m_state = ST_OVER;
      end else begin
        m_stab = score;
        if (v.clr != 0 && m_age >= SETTLE) begin
          if (m_state == NP) m_state = ST_CLEAR;
          else               enter_phase(m_state + 1);
        end else begin
          m_age++;
        end
      end
    end else if (v.start != 0) begin
      m_state = 0;
      m_stab  = SMAX;
    end
  endtask

  task automatic apply(input vec_t v);
    start_btn      = (v.start != 0);
    phase_clear    = (v.clr != 0);
    time_out       = (v.tout != 0);
    puzzle_fail    = (v.pf != 0);
    event_fail     = (v.ef != 0);
    puzzle_correct = (v.pc != 0);
    debug_force    = (v.df != 0);
    debug_state    = 4'(v.ds);
  endtask

  task automatic step(input vec_t v);
    apply(v);
    @(posedge clk);
    model_step(v);
    #1;
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v = '{0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0};
    return v;
  endfunction

  task automatic check_outputs(input string tag, input int st, input int sb,
                               input int en, input int tr, input int pe,
                               input int cl, input int ov);
    check({tag, ".state"},       int'(current_state), st);
    check({tag, ".stability"},   int'(stability),     sb);
    check({tag, ".game_enable"}, int'(game_enable),   en);
    check({tag, ".timer_reset"}, int'(timer_reset),   tr);
    check({tag, ".phase_enter"}, int'(phase_enter),   pe);
    check({tag, ".game_clear"},  int'(game_clear),    cl);
    check({tag, ".game_over"},   int'(game_over),     ov);
  endtask

  task automatic check_model(input string tag);
    check_outputs(tag, m_state, m_stab,
                  int'(m_state >= 1 && m_state <= NP), m_trst, m_pent,
                  int'(m_state == ST_CLEAR), int'(m_state == ST_OVER));
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;

    // start clr tout pf ef pc df ds | state stab en trst pent clear over
    tbl.push_back(vec_t'{0,0,0,0,0,0,0,0, 0,9,0,0,0,0,0}); // idle
    tbl.push_back(vec_t'{0,0,0,1,0,0,0,0, 0,9,0,0,0,0,0}); // fail ignored in IDLE
    tbl.push_back(vec_t'{1,0,0,0,0,0,0,0, 1,9,1,1,1,0,0}); // start
    tbl.push_back(vec_t'{0,0,0,0,0,1,0,0, 1,9,1,0,0,0,0}); // recover saturates
    tbl.push_back(vec_t'{0,0,0,1,1,0,0,0, 1,6,1,0,0,0,0}); // fail+event
    tbl.push_back(vec_t'{0,1,0,1,0,0,0,0, 1,5,1,0,0,0,0}); // clear dropped in settle
    tbl.push_back(vec_t'{0,0,0,1,1,1,0,0, 1,3,1,0,0,0,0}); // combined update
    tbl.push_back(vec_t'{0,1,0,0,0,0,0,0, 2,3,1,0,1,0,0}); // clear after settle
    tbl.push_back(vec_t'{0,0,0,0,1,0,0,0, 2,1,1,0,0,0,0});
    tbl.push_back(vec_t'{0,0,0,0,1,0,0,0, 6,0,0,0,0,0,1}); // depletion -> OVER
    tbl.push_back(vec_t'{0,0,0,0,0,1,0,0, 6,0,0,0,0,0,1}); // frozen in OVER
    tbl.push_back(vec_t'{0,0,1,0,0,0,0,0, 6,0,0,0,0,0,1});
    tbl.push_back(vec_t'{0,0,0,0,0,0,1,7, 6,0,0,0,0,0,1}); // out-of-range jump
    tbl.push_back(vec_t'{0,0,0,0,0,0,1,2, 2,9,1,1,1,0,0}); // jump from OVER
    tbl.push_back(vec_t'{0,0,0,0,0,0,1,0, 2,9,1,0,0,0,0}); // jump to 0 ignored
    tbl.push_back(vec_t'{0,1,1,0,0,0,0,0, 6,9,0,0,0,0,1}); // time_out beats clear
    tbl.push_back(vec_t'{1,0,0,0,0,0,0,0, 0,9,0,0,0,0,0}); // ack -> IDLE
    tbl.push_back(vec_t'{1,0,0,0,0,0,0,0, 1,9,1,1,1,0,0});
    tbl.push_back(vec_t'{0,0,0,1,0,0,1,4, 4,9,1,1,1,0,0}); // jump beats fail
    for (int i = 0; i < 4; i++)
      tbl.push_back(vec_t'{0,0,0,0,0,0,0,0, 4,9,1,0,0,0,0});
    tbl.push_back(vec_t'{0,1,0,0,1,0,0,0, 5,7,0,0,0,1,0}); // last phase -> CLEAR
    tbl.push_back(vec_t'{0,0,0,1,0,0,0,0, 5,7,0,0,0,1,0}); // frozen in CLEAR
    tbl.push_back(vec_t'{0,0,0,0,0,0,1,3, 3,9,1,1,1,0,0}); // jump from CLEAR
    tbl.push_back(vec_t'{1,0,0,0,0,0,0,0, 3,9,1,0,0,0,0}); // start ignored in phase

    // Reset state.
    rst = 1'b1;
    apply(idle_vec());
    model_reset();
    #1;
    check_outputs("reset", 0, SMAX, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed table.
    foreach (tbl[i]) begin
      step(tbl[i]);
      check_outputs($sformatf("tbl%0d", i), tbl[i].e_state, tbl[i].e_stab,
                    tbl[i].e_en, tbl[i].e_trst, tbl[i].e_pent,
                    tbl[i].e_clear, tbl[i].e_over);
    end

    // Full game with phase_clear held: one phase every SETTLE+1 cycles.
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    v = idle_vec();
    v.start = 1;
    step(v);
    check_outputs("game.start", 1, SMAX, 1, 1, 1, 0, 0);
    v = idle_vec();
    v.clr = 1;
    for (int c = 1; c <= NP * (SETTLE + 1); c++) begin
      step(v);
      if (c < NP * (SETTLE + 1))
        check_outputs($sformatf("game.c%0d", c), 1 + c / (SETTLE + 1), SMAX,
                      1, 0, int'(c % (SETTLE + 1) == 0), 0, 0);
      else
        check_outputs("game.clear", ST_CLEAR, SMAX, 0, 0, 0, 1, 0);
    end
    v = idle_vec();
    v.start = 1;
    step(v);
    check_outputs("game.ack", 0, SMAX, 0, 0, 0, 0, 0);

    // Asynchronous reset from PHASE 3 with stability 4.
    step(v);                                  // start -> PHASE 1
    v = idle_vec(); v.df = 1; v.ds = 3;
    step(v);                                  // jump -> PHASE 3
    v = idle_vec(); v.ef = 1;
    step(v);
    step(v);                                  // 9 -> 7 -> 5
    v = idle_vec(); v.pf = 1;
    step(v);                                  // 5 -> 4
    check_outputs("pre_rst", 3, 4, 1, 0, 0, 0, 0);
    #4;
    rst = 1'b1;
    #1;
    check_outputs("async_rst", 0, SMAX, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(idle_vec());
    check_outputs("post_rst", 0, SMAX, 0, 0, 0, 0, 0);

    // Randomized stimulus against the reference model.
    for (int n = 0; n < 2000; n++) begin
      v = idle_vec();
      v.start = int'($urandom_range(0, 15) == 0);
      v.clr   = int'($urandom_range(0, 3) == 0);
      v.tout  = int'($urandom_range(0, 63) == 0);
      v.pf    = int'($urandom_range(0, 7) == 0);
      v.ef    = int'($urandom_range(0, 7) == 0);
      v.pc    = int'($urandom_range(0, 5) == 0);
      v.df    = int'($urandom_range(0, 31) == 0);
      v.ds    = int'($urandom_range(0, 15));
      step(v);
      check_model($sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
